// File: rtl/cac_dec_sched_if.sv
// Bus-side handshake bundle for cac_dec_sched: input word channel and decoded output channel.
// The slave modport is the decoder's view; the master modport is the upstream/downstream view.
interface cac_dec_sched_if #(
   parameter int NUM_GRP = 4,
   parameter int DW      = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [4*NUM_GRP-1:0]    codein_all;
   logic                    out_valid;
   logic                    out_ready;
   logic [DW*NUM_GRP-1:0]   dataout_all;

   modport master (
      output in_valid, codein_all, out_ready,
      input  in_ready, out_valid, dataout_all
   );

   modport slave (
      input  in_valid, codein_all, out_ready,
      output in_ready, out_valid, dataout_all
   );
endinterface

// File: rtl/cac_dec_sched.sv
// Time-multiplexed FNS/CAC decoder: one 4-bit codeword group per cycle across a latched bus word.
// Optional macro CACDEC_SCHED_CHK_EN adds the forbidden-pattern flag output chk_err.
module cac_dec_sched #(
   parameter int NUM_GRP = 4,
   parameter int DW      = 4,
   parameter int WL      = 2,
   parameter int W3_RST  = 2,
   parameter int W4_RST  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   cac_dec_sched_if.slave      bus,
   input  logic                cfg_we,
   input  logic                cfg_sel,
   input  logic [WL-1:0]       cfg_wdata,
   output logic                cfg_err,
`ifdef CACDEC_SCHED_CHK_EN
   output logic [NUM_GRP-1:0]  chk_err,
`endif
   output logic                busy
);
   localparam int CW = $clog2(NUM_GRP);
   localparam int SW = DW + 1;

   typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

   state_t                 state_reg;
   logic [CW-1:0]          grp_cnt_reg;
   logic [4*NUM_GRP-1:0]   code_reg;
   logic [WL-1:0]          w3_reg;
   logic [WL-1:0]          w4_reg;
   logic                   in_ready_reg;
   logic                   out_valid_reg;
   logic                   cfg_err_reg;
   logic                   busy_reg;
   logic [DW-1:0]          dout_reg [NUM_GRP];
   logic [3:0]             code_grp [NUM_GRP];
   logic [3:0]             cur_code;
   logic [SW-1:0]          dec_sum;
   logic                   accept;

   assign accept = bus.in_valid && in_ready_reg;

   generate
      for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
         assign code_grp[gi] = code_reg[4*gi +: 4];
         assign bus.dataout_all[DW*gi +: DW] = dout_reg[gi];

         // Each slice is only overwritten on its own decode slot, so the previous word lingers until then.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout_reg[gi] <= '0;
            end else if (state_reg == DECODE && grp_cnt_reg == CW'(gi)) begin
               dout_reg[gi] <= dec_sum[DW-1:0];
            end
         end
      end
   endgenerate

   // The single shared decoder; sum kept one bit wider, then truncated on write.
   always_comb begin
      cur_code = code_grp[grp_cnt_reg];
      dec_sum  = SW'(cur_code[0]) + SW'(cur_code[1])
               + (cur_code[2] ? SW'(w3_reg) : '0)
               + (cur_code[3] ? SW'(w4_reg) : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         grp_cnt_reg   <= '0;
         code_reg      <= '0;
         w3_reg        <= WL'(W3_RST);
         w4_reg        <= WL'(W4_RST);
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         cfg_err_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         cfg_err_reg <= 1'b0;
         // Weights may only change between words, which keeps them constant across a decode.
         if (cfg_we) begin
            if (state_reg == IDLE) begin
               if (cfg_sel) w4_reg <= cfg_wdata;
               else         w3_reg <= cfg_wdata;
            end else begin
               cfg_err_reg <= 1'b1;
            end
         end
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  code_reg     <= bus.codein_all;
                  grp_cnt_reg  <= '0;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= DECODE;
               end
            end
            DECODE: begin
               if (grp_cnt_reg == CW'(NUM_GRP - 1)) begin
                  grp_cnt_reg   <= '0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  grp_cnt_reg <= grp_cnt_reg + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign cfg_err       = cfg_err_reg;
   assign busy          = busy_reg;

`ifdef CACDEC_SCHED_CHK_EN
   logic [NUM_GRP-1:0] chk_reg;
   logic               pat_hit;

   // Alternating 010/101 in either 3-bit window marks a forbidden pattern.
   assign pat_hit = (cur_code[2:0] == 3'b010) || (cur_code[2:0] == 3'b101)
                 || (cur_code[3:1] == 3'b010) || (cur_code[3:1] == 3'b101);

   generate
      for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_chk
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               chk_reg[gi] <= 1'b0;
            end else if (accept) begin
               chk_reg[gi] <= 1'b0;
            end else if (state_reg == DECODE && grp_cnt_reg == CW'(gi) && pat_hit) begin
               chk_reg[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   assign chk_err = chk_reg;
`endif
endmodule

// File: tb/tb_cac_dec_sched.sv
// Directed bench for cac_dec_sched: latency, back-pressure, weight writes, truncation-free sums, mid-word reset.
module tb_cac_dec_sched;
   localparam int NUM_GRP = 4;
   localparam int DW      = 4;
   localparam int WL      = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we;
   logic          cfg_sel;
   logic [WL-1:0] cfg_wdata;
   logic          cfg_err;
   logic          busy;
`ifdef CACDEC_SCHED_CHK_EN
   logic [NUM_GRP-1:0] chk_err;
`endif

   int errors = 0;
   int checks = 0;

   cac_dec_sched_if #(.NUM_GRP(NUM_GRP), .DW(DW)) bus ();

   cac_dec_sched #(.NUM_GRP(NUM_GRP), .DW(DW), .WL(WL), .W3_RST(2), .W4_RST(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_wdata (cfg_wdata),
      .cfg_err   (cfg_err),
`ifdef CACDEC_SCHED_CHK_EN
      .chk_err   (chk_err),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] word);
      bus.codein_all = word;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid   = 1'b0;
   endtask

   task automatic release_out(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.codein_all = '0;
      bus.out_ready  = 1'b0;
      cfg_we         = 1'b0;
      cfg_sel        = 1'b0;
      cfg_wdata      = '0;
      repeat (2) @(negedge clk);

      check("rst_in_ready",  32'(bus.in_ready),    32'd1);
      check("rst_out_valid", 32'(bus.out_valid),   32'd0);
      check("rst_dataout",   32'(bus.dataout_all), 32'd0);
      check("rst_cfg_err",   32'(cfg_err),         32'd0);
      check("rst_busy",      32'(busy),            32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Default weights: {1001,0110,1111,0000} -> {4,3,7,0}, valid exactly 4 edges after accept
      send(16'h96F0);
      check("t1_in_ready", 32'(bus.in_ready),  32'd0);
      check("t1_busy",     32'(busy),          32'd1);
      repeat (3) tick();
      check("t1_lat3_ov",  32'(bus.out_valid), 32'd0);
      tick();
      check("t1_lat4_ov",  32'(bus.out_valid), 32'd1);
      check("t1_data",     32'(bus.dataout_all), 32'h4370);

      // Back-pressure: output held, a pending word not accepted
      bus.codein_all = 16'h1111;
      bus.in_valid   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2_hold_ov",   32'(bus.out_valid),   32'd1);
         check("t2_hold_data", 32'(bus.dataout_all), 32'h4370);
         check("t2_hold_rdy",  32'(bus.in_ready),    32'd0);
      end
      release_out("t2");
      check("t2_rdy_back", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("t2_acc_busy",  32'(busy),            32'd1);
      check("t2_old_kept",  32'(bus.dataout_all), 32'h4370);
      tick();
      check("t2_grp0_only", 32'(bus.dataout_all), 32'h4371);
      repeat (3) tick();
      check("t2_ov",   32'(bus.out_valid),   32'd1);
      check("t2_data", 32'(bus.dataout_all), 32'h1111);
      release_out("t2b");

      // W4 write with same-cycle accept, then rejected W3 write during DECODE
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_wdata = 2'd3;
      send(16'hCCCC);
      check("t3_wr_ok_err", 32'(cfg_err), 32'd0);
      cfg_sel = 1'b0; cfg_wdata = 2'd1;
      tick();
      cfg_we = 1'b0;
      check("t3_rej_err",  32'(cfg_err), 32'd1);
      tick();
      check("t3_err_pulse", 32'(cfg_err), 32'd0);
      repeat (2) tick();
      check("t3_ov",   32'(bus.out_valid),   32'd1);
      check("t3_data", 32'(bus.dataout_all), 32'h5555);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 2'd0;
      tick();
      cfg_we = 1'b0;
      check("t3_done_err", 32'(cfg_err), 32'd1);
      release_out("t3");

      // W3=3, W4=3: 1111 -> 8 per group
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 2'd3;
      tick();
      cfg_we = 1'b0;
      check("t4_idle_wr_err", 32'(cfg_err), 32'd0);
      send(16'hFFFF);
      repeat (4) tick();
      check("t4_ov",   32'(bus.out_valid),   32'd1);
      check("t4_data", 32'(bus.dataout_all), 32'h8888);
      release_out("t4");

      // W4=1 written on the accept edge: {1000,1100,0100,0000} -> {1,4,3,0}
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_wdata = 2'd1;
      send(16'h8C40);
      cfg_we = 1'b0;
      repeat (4) tick();
      check("t4b_data", 32'(bus.dataout_all), 32'h1430);
      release_out("t4b");

      // Reset with grp_cnt=2: groups 0,1 already hold 1+1+3+1=6
      send(16'hFFFF);
      repeat (2) tick();
      check("t5_partial", 32'(bus.dataout_all), 32'h1466);
      rst_n = 1'b0;
      #1;
      check("t5_rst_ov",   32'(bus.out_valid),   32'd0);
      check("t5_rst_rdy",  32'(bus.in_ready),    32'd1);
      check("t5_rst_busy", 32'(busy),            32'd0);
      check("t5_rst_data", 32'(bus.dataout_all), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'h96F0);
      repeat (4) tick();
      check("t5_wt_reset_data", 32'(bus.dataout_all), 32'h4370);
      release_out("t5");

      // {0101,0011,1010,0000} -> {3,2,4,0}; forbidden-pattern flags 1010
      send(16'h53A0);
      repeat (4) tick();
      check("t6_data", 32'(bus.dataout_all), 32'h3240);
`ifdef CACDEC_SCHED_CHK_EN
      check("t6_chk", 32'(chk_err), 32'hA);
`endif
      release_out("t6");
      send(16'h0000);
`ifdef CACDEC_SCHED_CHK_EN
      check("t6_chk_clr", 32'(chk_err), 32'd0);
`endif
      repeat (4) tick();
      check("t6b_data", 32'(bus.dataout_all), 32'h0000);
      release_out("t6b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
